// File: rtl/em_seek_dispatcher.sv
// rtl/em_seek_dispatcher.sv - allocates read jobs to NUM_ENG seek engines and reports per-read completion
module em_seek_dispatcher #(
    parameter int NUM_ENG   = 4,
    parameter int POS_W     = 8,
    parameter int RID_W     = 16,
    parameter int START_POS = 1,
    parameter int PASS_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_read_valid,
    output logic                     s_read_ready,
    input  logic [RID_W-1:0]         s_read_id,
    input  logic [POS_W-1:0]         s_read_len,
    input  logic                     s_read_bidir,
    output logic [NUM_ENG-1:0]       eng_start,
    output logic [NUM_ENG*POS_W-1:0] eng_pos_in,
    output logic [NUM_ENG-1:0]       eng_bi_dir,
    output logic [NUM_ENG*RID_W-1:0] eng_read_id,
    input  logic [NUM_ENG-1:0]       eng_finish,
    input  logic [NUM_ENG*POS_W-1:0] eng_pos_out,
    output logic                     m_done_valid,
    input  logic                     m_done_ready,
    output logic [RID_W-1:0]         m_done_id,
    output logic [PASS_W-1:0]        m_done_passes,
    output logic                     m_done_err,
    output logic                     idle,
    output logic                     err_spurious
);
    localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [POS_W:0]   START_W = (POS_W+1)'(START_POS);
    localparam logic [POS_W-1:0] START_P = POS_W'(START_POS);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_WAIT, ST_CHECK, ST_DONE} state_e;

    state_e              st_q     [NUM_ENG];
    logic [RID_W-1:0]    id_q     [NUM_ENG];
    logic [POS_W-1:0]    len_q    [NUM_ENG];
    logic [POS_W-1:0]    pos_q    [NUM_ENG];
    logic [POS_W-1:0]    pout_q   [NUM_ENG];
    logic [PASS_W-1:0]   passes_q [NUM_ENG];
    logic [NUM_ENG-1:0]  err_q;
    logic [NUM_ENG-1:0]  eng_start_q;
    logic [NUM_ENG-1:0]  eng_bi_dir_q;
    logic [NUM_ENG*POS_W-1:0] eng_pos_q;
    logic [NUM_ENG*RID_W-1:0] eng_id_q;
    logic                live_q;
    logic                done_valid_q;
    logic [RID_W-1:0]    done_id_q;
    logic [PASS_W-1:0]   done_passes_q;
    logic                done_err_q;
    logic [IDX_W-1:0]    last_q;
    logic                err_spur_q;

    logic                any_idle, all_idle, acc_found, accept;
    logic [IDX_W-1:0]    acc_sel;
    logic [NUM_ENG-1:0]  req, forced;
    logic [POS_W:0]      npos [NUM_ENG];
    logic                gnt_any, grant, load;
    logic [IDX_W-1:0]    gnt_idx;

    // Extra bit keeps pos_out = 2^POS_W-1 and the forced +1 from wrapping.
    always_comb begin
        any_idle  = 1'b0;
        all_idle  = 1'b1;
        acc_found = 1'b0;
        acc_sel   = '0;
        req       = '0;
        forced    = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            npos[i] = {1'b0, pout_q[i]};
            if (st_q[i] == ST_IDLE) begin
                any_idle = 1'b1;
                if (!acc_found) begin
                    acc_found = 1'b1;
                    acc_sel   = IDX_W'(i);
                end
            end else begin
                all_idle = 1'b0;
            end
            req[i] = (st_q[i] == ST_DONE);
            if ({1'b0, pout_q[i]} <= {1'b0, pos_q[i]}) begin
                forced[i] = 1'b1;
                npos[i]   = {1'b0, pos_q[i]} + 1'b1;
            end
        end
    end

    always_comb begin : rr_arb
        int j;
        j       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NUM_ENG; k++) begin
            j = int'(last_q) + k;
            if (j >= NUM_ENG) j = j - NUM_ENG;
            if (!gnt_any && req[IDX_W'(j)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(j);
            end
        end
    end

    assign s_read_ready = live_q & any_idle;
    assign accept       = s_read_valid & s_read_ready;
    assign load         = !done_valid_q | m_done_ready;
    assign grant        = gnt_any & load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENG; i++) begin
                st_q[i]     <= ST_IDLE;
                id_q[i]     <= '0;
                len_q[i]    <= '0;
                pos_q[i]    <= '0;
                pout_q[i]   <= '0;
                passes_q[i] <= '0;
            end
            err_q         <= '0;
            eng_start_q   <= '0;
            eng_bi_dir_q  <= '0;
            eng_pos_q     <= '0;
            eng_id_q      <= '0;
            live_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            done_id_q     <= '0;
            done_passes_q <= '0;
            done_err_q    <= 1'b0;
            last_q        <= IDX_W'(NUM_ENG - 1);
            err_spur_q    <= 1'b0;
        end else begin
            live_q      <= 1'b1;
            eng_start_q <= '0;
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng_finish[i] && st_q[i] != ST_WAIT) err_spur_q <= 1'b1;
                case (st_q[i])
                    ST_IDLE: if (accept && acc_sel == IDX_W'(i)) begin
                        id_q[i]     <= s_read_id;
                        len_q[i]    <= s_read_len;
                        pos_q[i]    <= START_P;
                        passes_q[i] <= '0;
                        err_q[i]    <= 1'b0;
                        if ({1'b0, s_read_len} <= START_W) begin
                            st_q[i] <= ST_DONE;
                        end else begin
                            st_q[i]                    <= ST_START;
                            eng_start_q[i]             <= 1'b1;
                            eng_pos_q[i*POS_W +: POS_W] <= START_P;
                            eng_bi_dir_q[i]            <= s_read_bidir;
                            eng_id_q[i*RID_W +: RID_W] <= s_read_id;
                        end
                    end
                    ST_START: st_q[i] <= ST_WAIT;
                    ST_WAIT: if (eng_finish[i]) begin
                        pout_q[i] <= eng_pos_out[i*POS_W +: POS_W];
                        if (passes_q[i] != '1) passes_q[i] <= passes_q[i] + 1'b1;
                        st_q[i] <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        pos_q[i] <= npos[i][POS_W-1:0];
                        if (forced[i]) err_q[i] <= 1'b1;
                        if (npos[i] >= {1'b0, len_q[i]}) begin
                            st_q[i] <= ST_DONE;
                        end else begin
                            st_q[i]                     <= ST_START;
                            eng_start_q[i]              <= 1'b1;
                            eng_pos_q[i*POS_W +: POS_W] <= npos[i][POS_W-1:0];
                        end
                    end
                    ST_DONE: if (grant && gnt_idx == IDX_W'(i)) st_q[i] <= ST_IDLE;
                    default: st_q[i] <= ST_IDLE;
                endcase
            end
            if (grant) begin
                done_valid_q  <= 1'b1;
                done_id_q     <= id_q[gnt_idx];
                done_passes_q <= passes_q[gnt_idx];
                done_err_q    <= err_q[gnt_idx];
                last_q        <= gnt_idx;
            end else if (m_done_ready) begin
                done_valid_q <= 1'b0;
            end
        end
    end

    assign eng_start     = eng_start_q;
    assign eng_pos_in    = eng_pos_q;
    assign eng_bi_dir    = eng_bi_dir_q;
    assign eng_read_id   = eng_id_q;
    assign m_done_valid  = done_valid_q;
    assign m_done_id     = done_id_q;
    assign m_done_passes = done_passes_q;
    assign m_done_err    = done_err_q;
    assign idle          = all_idle & !done_valid_q;
    assign err_spurious  = err_spur_q;
endmodule

// File: tb/tb_em_seek_dispatcher.sv
// tb/tb_em_seek_dispatcher.sv - directed self-checking bench for em_seek_dispatcher
module tb_em_seek_dispatcher;
    localparam int NUM_ENG = 4;
    localparam int POS_W   = 8;
    localparam int RID_W   = 16;
    localparam int PASS_W  = 8;
    localparam int NV      = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_read_valid = 1'b0;
    logic s_read_ready;
    logic [RID_W-1:0] s_read_id = '0;
    logic [POS_W-1:0] s_read_len = '0;
    logic s_read_bidir = 1'b0;
    logic [NUM_ENG-1:0] eng_start;
    logic [NUM_ENG*POS_W-1:0] eng_pos_in;
    logic [NUM_ENG-1:0] eng_bi_dir;
    logic [NUM_ENG*RID_W-1:0] eng_read_id;
    logic [NUM_ENG-1:0] eng_finish = '0;
    logic [NUM_ENG*POS_W-1:0] eng_pos_out = '0;
    logic m_done_valid;
    logic m_done_ready = 1'b0;
    logic [RID_W-1:0] m_done_id;
    logic [PASS_W-1:0] m_done_passes;
    logic m_done_err;
    logic idle;
    logic err_spurious;

    always #5 clk = ~clk;

    em_seek_dispatcher #(.NUM_ENG(NUM_ENG), .POS_W(POS_W), .RID_W(RID_W), .START_POS(1), .PASS_W(PASS_W)) dut (
        .clk(clk), .rst(rst),
        .s_read_valid(s_read_valid), .s_read_ready(s_read_ready), .s_read_id(s_read_id),
        .s_read_len(s_read_len), .s_read_bidir(s_read_bidir),
        .eng_start(eng_start), .eng_pos_in(eng_pos_in), .eng_bi_dir(eng_bi_dir), .eng_read_id(eng_read_id),
        .eng_finish(eng_finish), .eng_pos_out(eng_pos_out),
        .m_done_valid(m_done_valid), .m_done_ready(m_done_ready), .m_done_id(m_done_id),
        .m_done_passes(m_done_passes), .m_done_err(m_done_err),
        .idle(idle), .err_spurious(err_spurious)
    );

    typedef struct packed {
        logic [15:0]     id;
        logic [7:0]      len;
        logic            bidir;
        logic [1:0]      npass;
        logic [0:2][7:0] pout;
        logic [0:2][7:0] starts;
        logic [7:0]      passes;
        logic            err;
    } vec_t;

    vec_t vecs [NV];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_read_valid = 1'b0;
        s_read_id    = '0;
        s_read_len   = '0;
        s_read_bidir = 1'b0;
        eng_finish   = '0;
        eng_pos_out  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_eng_start"}, 64'(eng_start), 64'h0);
        check({tag, "_eng_pos_in"}, 64'(eng_pos_in), 64'h0);
        check({tag, "_eng_bi_dir"}, 64'(eng_bi_dir), 64'h0);
        check({tag, "_eng_read_id"}, 64'(eng_read_id), 64'h0);
        check({tag, "_ready"}, 64'(s_read_ready), 64'h0);
        check({tag, "_done_bus"}, {m_done_valid, m_done_id, m_done_passes, m_done_err}, 64'h0);
        check({tag, "_err_spurious"}, 64'(err_spurious), 64'h0);
        check({tag, "_idle"}, 64'(idle), 64'h1);
    endtask

    initial begin
        int got_n, stall_bad, quiet_bad;
        logic held;
        logic [RID_W-1:0] held_id;
        logic [RID_W-1:0] got [8];

        vecs[0] = '{id: 16'h0005, len: 8'd78,  bidir: 1'b1, npass: 2'd3,
                    pout: {8'd20, 8'd45, 8'd78}, starts: {8'd1, 8'd20, 8'd45}, passes: 8'd3, err: 1'b0};
        vecs[1] = '{id: 16'h0030, len: 8'd40,  bidir: 1'b0, npass: 2'd3,
                    pout: {8'd30, 8'd30, 8'd50}, starts: {8'd1, 8'd30, 8'd31}, passes: 8'd3, err: 1'b1};
        vecs[2] = '{id: 16'h00FF, len: 8'd255, bidir: 1'b1, npass: 2'd2,
                    pout: {8'd100, 8'd255, 8'd0}, starts: {8'd1, 8'd100, 8'd0}, passes: 8'd2, err: 1'b0};
        vecs[3] = '{id: 16'h0001, len: 8'd1,   bidir: 1'b1, npass: 2'd0,
                    pout: {8'd0, 8'd0, 8'd0}, starts: {8'd0, 8'd0, 8'd0}, passes: 8'd0, err: 1'b0};
        vecs[4] = '{id: 16'hABCD, len: 8'd10,  bidir: 1'b0, npass: 2'd2,
                    pout: {8'd0, 8'd10, 8'd0}, starts: {8'd1, 8'd2, 8'd0}, passes: 8'd2, err: 1'b1};
        vecs[5] = '{id: 16'h1234, len: 8'd255, bidir: 1'b1, npass: 2'd2,
                    pout: {8'd254, 8'd3, 8'd0}, starts: {8'd1, 8'd254, 8'd0}, passes: 8'd2, err: 1'b1};

        #2 rst = 1'b1;
        #1 check_reset_outputs("por");
        tick();
        rst = 1'b0;
        tick();

        // Single-read vectors on engine 0, exact pass latency.
        for (int v = 0; v < NV; v++) begin
            do_reset();
            m_done_ready = 1'b1;
            s_read_valid = 1'b1;
            s_read_id    = vecs[v].id;
            s_read_len   = vecs[v].len;
            s_read_bidir = vecs[v].bidir;
            tick();
            s_read_valid = 1'b0;
            for (int p = 0; p < 3; p++) begin
                if (p < int'(vecs[v].npass)) begin
                    check($sformatf("v%0d_p%0d_start", v, p), 64'(eng_start), 64'h1);
                    check($sformatf("v%0d_p%0d_pos_in", v, p), 64'(eng_pos_in[7:0]), 64'(vecs[v].starts[p]));
                    check($sformatf("v%0d_p%0d_bidir", v, p), 64'(eng_bi_dir[0]), 64'(vecs[v].bidir));
                    check($sformatf("v%0d_p%0d_rid", v, p), 64'(eng_read_id[15:0]), 64'(vecs[v].id));
                    tick();
                    eng_finish[0]     = 1'b1;
                    eng_pos_out[7:0]  = vecs[v].pout[p];
                    tick();
                    eng_finish[0] = 1'b0;
                    check($sformatf("v%0d_p%0d_gap", v, p), 64'(eng_start), 64'h0);
                    tick();
                end
            end
            check($sformatf("v%0d_no_extra_start", v), 64'(eng_start), 64'h0);
            tick();
            check($sformatf("v%0d_done_valid", v), 64'(m_done_valid), 64'h1);
            check($sformatf("v%0d_done_id", v), 64'(m_done_id), 64'(vecs[v].id));
            check($sformatf("v%0d_done_passes", v), 64'(m_done_passes), 64'(vecs[v].passes));
            check($sformatf("v%0d_done_err", v), 64'(m_done_err), 64'(vecs[v].err));
            tick();
            check($sformatf("v%0d_idle_after", v), {m_done_valid, idle}, 64'h1);
        end

        // Allocation: five jobs back-to-back, job 4 waits for the first freed engine.
        do_reset();
        m_done_ready = 1'b1;
        s_read_len   = 8'd50;
        for (int k = 0; k < 4; k++) begin
            s_read_valid = 1'b1;
            s_read_id    = 16'h0010 + 16'(k);
            check($sformatf("alloc_ready_%0d", k), 64'(s_read_ready), 64'h1);
            tick();
            check($sformatf("alloc_start_%0d", k), 64'(eng_start), 64'(1 << k));
            check($sformatf("alloc_rid_%0d", k), 64'(eng_read_id[k*RID_W +: RID_W]), 64'h10 + 64'(k));
        end
        s_read_id = 16'h0014;
        check("alloc_full_ready", 64'(s_read_ready), 64'h0);
        tick();
        check("alloc_full_start", 64'(eng_start), 64'h0);
        eng_finish[2]     = 1'b1;
        eng_pos_out[23:16] = 8'd50;
        tick();
        eng_finish = '0;
        check("alloc_check_ready", 64'(s_read_ready), 64'h0);
        tick();
        check("alloc_grant_ready", 64'(s_read_ready), 64'h0);
        tick();
        check("alloc_freed_ready", 64'(s_read_ready), 64'h1);
        check("alloc_done", {m_done_valid, m_done_id}, {1'b1, 16'h0012});
        tick();
        s_read_valid = 1'b0;
        check("alloc_job4_start", 64'(eng_start), 64'h4);
        check("alloc_job4_rid", 64'(eng_read_id[2*RID_W +: RID_W]), 64'h14);

        // Fairness under 1:3 backpressure: all four engines finish together.
        do_reset();
        m_done_ready = 1'b0;
        s_read_len   = 8'd10;
        for (int k = 0; k < 4; k++) begin
            s_read_valid = 1'b1;
            s_read_id    = 16'h0020 + 16'(k);
            tick();
        end
        s_read_valid = 1'b0;
        tick();
        eng_pos_out = {4{8'd10}};
        eng_finish  = 4'hF;
        tick();
        eng_finish = '0;
        got_n = 0;
        stall_bad = 0;
        held = 1'b0;
        held_id = '0;
        for (int c = 0; c < 40; c++) begin
            m_done_ready = (c % 4 == 3);
            if (held && (!m_done_valid || m_done_id !== held_id)) stall_bad++;
            held = 1'b0;
            if (m_done_valid) begin
                if (m_done_ready) begin
                    if (got_n < 8) got[got_n] = m_done_id;
                    got_n++;
                end else begin
                    held    = 1'b1;
                    held_id = m_done_id;
                end
            end
            tick();
        end
        m_done_ready = 1'b0;
        check("rr_stall_stable", 64'(stall_bad), 64'h0);
        check("rr_count", 64'(got_n), 64'h4);
        for (int k = 0; k < 4; k++) begin
            if (k < got_n) check($sformatf("rr_order_%0d", k), 64'(got[k]), 64'h20 + 64'(k));
        end
        check("rr_idle_end", 64'(idle), 64'h1);

        // Spurious finish on an idle engine, then reset while two engines are in WAIT.
        do_reset();
        s_read_len   = 8'd50;
        s_read_valid = 1'b1;
        s_read_id    = 16'h0040;
        tick();
        s_read_id    = 16'h0041;
        tick();
        s_read_valid = 1'b0;
        tick();
        check("spur_before", 64'(err_spurious), 64'h0);
        eng_finish = 4'b1000;
        tick();
        eng_finish = '0;
        check("spur_set", 64'(err_spurious), 64'h1);
        tick();
        tick();
        check("spur_sticky", 64'(err_spurious), 64'h1);
        check("busy_not_idle", 64'(idle), 64'h0);
        rst = 1'b1;
        #1 check_reset_outputs("midwait");
        tick();
        rst = 1'b0;
        m_done_ready = 1'b1;
        tick();
        quiet_bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_done_valid || eng_start != '0) quiet_bad++;
            tick();
        end
        check("post_reset_quiet", 64'(quiet_bad), 64'h0);
        check("post_reset_ready_idle", {s_read_ready, idle, err_spurious}, 64'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/em_seek_dispatcher.md
Name: em_seek_dispatcher

Overview:
Multi-engine successor to the single-engine bidirectional exact-match seek loop. The block accepts read jobs as read ID, length and direction mode. It allocates each job to one of NUM_ENG seek engines and iterates start/finish/pos_out passes until the whole read is covered. It then reports per-read completion. It sits between the read-fetch stage and an array of seek engines, which fetch their read symbols by read ID and share the occ lookup path elsewhere.

Parameters:
NUM_ENG, 4, number of seek engines driven (1..16)
POS_W, 8, read position width; must match engine POS_W
RID_W, 16, read ID width
START_POS, 1, first seek position (position 0 is the leading pad symbol)
PASS_W, 8, width of the per-read pass counter (saturating)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
s_read_valid  in  1  job valid
s_read_ready  out  1  job accepted when valid & ready
s_read_id  in  RID_W  read ID
s_read_len  in  POS_W  read length L, in symbols
s_read_bidir  in  1  bi_dir mode for all passes of this read
eng_start  out  NUM_ENG  one-cycle start pulse per engine
eng_pos_in  out  NUM_ENG*POS_W  seek position, engine i at bits [i*POS_W +: POS_W]
eng_bi_dir  out  NUM_ENG  bi_dir per engine
eng_read_id  out  NUM_ENG*RID_W  read ID per engine
eng_finish  in  NUM_ENG  pass-finished pulse per engine
eng_pos_out  in  NUM_ENG*POS_W  next position, valid with eng_finish
m_done_valid  out  1  completion valid
m_done_ready  in  1  completion consumer ready
m_done_id  out  RID_W  completed read ID
m_done_passes  out  PASS_W  number of passes run for that read
m_done_err  out  1  at least one forced-progress event occurred on this read
idle  out  1  all engines in IDLE and no completion pending
err_spurious  out  1  sticky: a finish pulse arrived outside WAIT

Behaviour:
- Reset values: all eng_* outputs 0, s_read_ready 0, m_done_valid 0, m_done_* 0, err_spurious 0, idle 1.
- Reset is asynchronous. Asserting it mid-operation drops all in-flight reads with no completion emitted; every FSM returns to IDLE.
- Per-engine FSM states: IDLE, START, WAIT, CHECK, DONE.
- IDLE: the engine is available.
- s_read_ready = 1 when any engine is in IDLE. A job goes to the lowest-index IDLE engine.
- On acceptance at cycle T, the engine latches id, len and bidir, sets pos = START_POS and passes = 0, and enters START at T+1.
- Special case: if len <= START_POS, the engine goes straight to DONE with passes = 0 and no start is issued.
- START: eng_start[i] is high for exactly one cycle; pos, bi_dir and read_id are presented on the engine outputs. The FSM then enters WAIT.
- eng_pos_in, eng_bi_dir and eng_read_id are held stable from START until the next START.
- WAIT: the FSM waits for eng_finish[i]. At that edge it captures eng_pos_out, increments passes (saturating at 2^PASS_W-1) and enters CHECK.
- CHECK, forced progress: if the captured pos_out <= current pos, then pos = pos + 1 and the per-read err flag is set. Otherwise pos = pos_out.
- CHECK, exit: if the new pos >= len, the FSM enters DONE. Otherwise it enters START.
- Pass latency: finish at cycle F gives the next start at F+2.
- Position arithmetic uses a POS_W+1 bit compare, so pos_out = 2^POS_W-1 does not wrap.
- DONE: the engine requests the completion port.
  - Round-robin arbitration among DONE engines, starting after the last granted index.
  - The output is a single register slice: it loads when m_done_valid is 0, or when valid & ready in the same cycle.
  - The granted engine returns to IDLE in the cycle its completion is loaded and is allocatable on the next cycle.
  - m_done_* are held stable while valid & !ready.
- eng_finish[i] in any state other than WAIT is ignored for sequencing and sets err_spurious. err_spurious clears only on reset.
- Same-cycle events: job acceptance and completion grant on different engines proceed independently. An engine freed by a grant is not reallocated in that same cycle.
- idle = 1 when all FSMs are in IDLE and m_done_valid is 0.

Test Plan:
- Single read, NUM_ENG=1: id=0x0005, len=78, bidir=1, engine returns pos_out 20, 45, 78 -> starts issued at pos 1, 20, 45. Completion: id 0x0005, passes=3, err=0. Each start comes 2 cycles after its finish.
- Allocation: 5 jobs presented back-to-back, NUM_ENG=4 -> engines 0..3 take jobs 0..3. s_read_ready drops to 0, and job 4 goes to the first engine that frees.
- Completion backpressure and fairness: all 4 engines reach DONE together, m_done_ready toggles 1:3 -> order is 0, 1, 2, 3. Outputs are stable while stalled, and no completion is lost or duplicated.
- No-progress: engine returns pos_out = pos_in = 30 -> next start at pos 31, and the completion has err=1.
- Edge lengths: len=1 -> immediate completion with passes=0 and no start pulse. len=255, POS_W=8, pos_out=255 -> completes without wrap.
- Reset mid-WAIT on 2 engines; spurious finish on an IDLE engine -> after reset, all outputs are 0 and idle=1. A spurious finish sets err_spurious=1 until the next reset.
